// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: datapath width, NOP encoding, FSM states.
package instr_fetch_pkg;

  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,  // issuing a fetch request
    F_WAIT = 2'd1,  // one request outstanding
    F_HOLD = 2'd2,  // response parked, decode stalled
    F_DROP = 2'd3   // stale response still to come back
  } fetch_state_e;

  // PC arithmetic wraps modulo 2**DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] pc_plus_4(input logic [DATA_WIDTH-1:0] pc);
    return pc + DATA_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction word and its PC while decode is stalled.
module fetch_skid_buf
  import instr_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [31:0]           data_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  valid_o,
  output logic [31:0]           data_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  logic                  valid_q;
  logic [31:0]           data_q;
  logic [DATA_WIDTH-1:0] pc_q;

  // Clear wins over load so a redirect always leaves the buffer empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding request FSM, skid buffer for
// decode stalls, stale-response dropping after redirects, and the IF/ID register.
// Request channel: a request transfers on a cycle where imem_req_valid_o and
// imem_req_ready_i are both high; valid is not sticky and the address may change
// while unaccepted. Response channel has no ready: imem_rsp_valid_i is a one-cycle
// pulse that must be consumed or discarded in that cycle.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_f_i,
  input  logic                  stall_d_i,
  input  logic                  flush_d_i,
  input  logic                  pc_src_e_i,
  input  logic [DATA_WIDTH-1:0] pc_target_addr_e_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [31:0]           imem_rsp_data_i,
  output logic [DATA_WIDTH-1:0] pc_f_o,
  output logic [31:0]           instr_d_o,
  output logic [DATA_WIDTH-1:0] pc_d_o,
  output logic [DATA_WIDTH-1:0] pc_plus_4_d_o,
  output logic                  valid_d_o
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [31:0]           instr_d_q, instr_d_d;
  logic [DATA_WIDTH-1:0] pc_d_q, pc_d_d;
  logic [DATA_WIDTH-1:0] pc4_d_q, pc4_d_d;
  logic                  valid_d_q, valid_d_d;

  logic                  req_valid, req_fire;
  logic                  skid_load, skid_clear, skid_valid;
  logic [31:0]           skid_data;
  logic [DATA_WIDTH-1:0] skid_pc;

  // rst_n gates the request so nothing is issued while reset is held.
  assign req_valid = rst_n && (state_q == F_REQ) && !stall_f_i && !pc_src_e_i;
  assign req_fire  = req_valid && imem_req_ready_i;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (imem_rsp_data_i),
    .pc_i    (req_pc_q),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .pc_o    (skid_pc)
  );

  // Next-state, PC and IF/ID update; redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    req_pc_d   = req_pc_q;
    instr_d_d  = instr_d_q;
    pc_d_d     = pc_d_q;
    pc4_d_d    = pc4_d_q;
    valid_d_d  = valid_d_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    // No new word this cycle: bubble unless decode is stalled (flush beats stall).
    if (flush_d_i || !stall_d_i) begin
      valid_d_d = 1'b0;
      instr_d_d = NOP_INSTR;
    end

    if (pc_src_e_i) begin
      pc_f_d     = pc_target_addr_e_i;
      valid_d_d  = 1'b0;
      instr_d_d  = NOP_INSTR;
      skid_clear = 1'b1;
      // An outstanding request with no same-cycle response will still return a
      // stale word; F_DROP waits for it. A response arriving now is discarded.
      if ((state_q == F_WAIT || state_q == F_DROP) && !imem_rsp_valid_i) begin
        state_d = F_DROP;
      end else begin
        state_d = F_REQ;
      end
    end else begin
      case (state_q)
        F_REQ: begin
          if (req_fire) begin
            req_pc_d = pc_f_q;
            state_d  = F_WAIT;
          end
        end
        F_WAIT: begin
          if (imem_rsp_valid_i) begin
            if (stall_d_i) begin
              skid_load = 1'b1;
              state_d   = F_HOLD;
            end else begin
              if (!flush_d_i) begin
                valid_d_d = 1'b1;
                instr_d_d = imem_rsp_data_i;
                pc_d_d    = req_pc_q;
                pc4_d_d   = pc_plus_4(req_pc_q);
              end
              pc_f_d  = pc_plus_4(req_pc_q);
              state_d = F_REQ;
            end
          end
        end
        F_HOLD: begin
          if (!stall_d_i && skid_valid) begin
            if (!flush_d_i) begin
              valid_d_d = 1'b1;
              instr_d_d = skid_data;
              pc_d_d    = skid_pc;
              pc4_d_d   = pc_plus_4(skid_pc);
            end
            pc_f_d     = pc_plus_4(skid_pc);
            skid_clear = 1'b1;
            state_d    = F_REQ;
          end
        end
        F_DROP: begin
          if (imem_rsp_valid_i) begin
            state_d = F_REQ;
          end
        end
        default: state_d = F_REQ;
      endcase
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= F_REQ;
      pc_f_q    <= RESET_PC;
      req_pc_q  <= '0;
      instr_d_q <= NOP_INSTR;
      pc_d_q    <= '0;
      pc4_d_q   <= '0;
      valid_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      req_pc_q  <= req_pc_d;
      instr_d_q <= instr_d_d;
      pc_d_q    <= pc_d_d;
      pc4_d_q   <= pc4_d_d;
      valid_d_q <= valid_d_d;
    end
  end

  assign imem_req_valid_o = req_valid;
  assign imem_addr_o      = pc_f_q;
  assign pc_f_o           = pc_f_q;
  assign instr_d_o        = instr_d_q;
  assign pc_d_o           = pc_d_q;
  assign pc_plus_4_d_o    = pc4_d_q;
  assign valid_d_o        = valid_d_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: reactive memory model plus IF/ID scoreboard, and one
// task per scenario with inline checks.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_f_i, stall_d_i, flush_d_i, pc_src_e_i;
  logic [31:0] pc_target_addr_e_i;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic [31:0] pc_f_o, instr_d_o, pc_d_o, pc_plus_4_d_o;
  logic        valid_d_o;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall_f_i          (stall_f_i),
    .stall_d_i          (stall_d_i),
    .flush_d_i          (flush_d_i),
    .pc_src_e_i         (pc_src_e_i),
    .pc_target_addr_e_i (pc_target_addr_e_i),
    .imem_req_valid_o   (imem_req_valid_o),
    .imem_req_ready_i   (imem_req_ready_i),
    .imem_addr_o        (imem_addr_o),
    .imem_rsp_valid_i   (imem_rsp_valid_i),
    .imem_rsp_data_i    (imem_rsp_data_i),
    .pc_f_o             (pc_f_o),
    .instr_d_o          (instr_d_o),
    .pc_d_o             (pc_d_o),
    .pc_plus_4_d_o      (pc_plus_4_d_o),
    .valid_d_o          (valid_d_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int unsigned cyc      = 0;
  int unsigned rsp_lat  = 1;   // cycles from accept edge to response cycle (1 = zero-wait)

  logic [95:0] exp_q[$];       // {instr, pc, pc+4} for every word that must reach IF/ID

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } pend_t;
  pend_t pend_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  // ---------------- memory model + scoreboard ----------------
  initial begin
    logic        hs, ld_prev, hold_prev, kill_prev;
    logic [31:0] hs_addr;
    logic [95:0] snap, got, e;
    pend_t       p;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'hDEAD_BEEF;
    ld_prev = 1'b0; hold_prev = 1'b0; kill_prev = 1'b0; snap = '0;
    forever begin
      @(negedge clk);
      #4;  // just before the rising edge: inputs and outputs are settled
      got = {instr_d_o, pc_d_o, pc_plus_4_d_o};
      if (rst_n) begin
        if (ld_prev && valid_d_o) begin
          chk_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_load: got unexpected IF/ID word %h pc %h, required no load", instr_d_o, pc_d_o);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) $display("FAIL sb_load: got %h required %h", got, e);
            else pass_cnt++;
          end
        end else if (ld_prev && !valid_d_o) begin
          chk_cnt++;
          if (instr_d_o !== NOP) $display("FAIL sb_bubble_nop: got %h required %h", instr_d_o, NOP);
          else pass_cnt++;
        end
        if (kill_prev) begin
          chk_cnt++;
          if (valid_d_o !== 1'b0 || instr_d_o !== NOP)
            $display("FAIL sb_kill: got valid=%b instr=%h required valid=0 instr=%h", valid_d_o, instr_d_o, NOP);
          else pass_cnt++;
        end
        if (hold_prev) begin
          chk_cnt++;
          if (got !== snap || valid_d_o !== 1'b1 && valid_d_o !== 1'b0)
            $display("FAIL sb_hold: got %h required %h", got, snap);
          else pass_cnt++;
        end
      end
      // Capture what the coming edge will do.
      hs      = imem_req_valid_o && imem_req_ready_i;
      hs_addr = imem_addr_o;
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (pc_src_e_i) exp_q.delete();
        if (hs) exp_q.push_back({mem_word(hs_addr), hs_addr, hs_addr + 32'd4});
      end
      ld_prev   = rst_n && !stall_d_i && !flush_d_i && !pc_src_e_i;
      hold_prev = rst_n && stall_d_i && !flush_d_i && !pc_src_e_i;
      kill_prev = rst_n && (flush_d_i || pc_src_e_i);
      snap      = got;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
        p.due  = cyc + rsp_lat - 1;
        p.addr = hs_addr;
        pend_q.push_back(p);
      end
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
        p = pend_q.pop_front();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = mem_word(p.addr);
      end else begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_hs(output logic [31:0] addr, output bit ok);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (imem_req_valid_o && imem_req_ready_i) begin
        ok   = 1'b1;
        addr = imem_addr_o;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // Stop fetching and let any outstanding word land in IF/ID.
  task automatic drain();
    @(negedge clk);
    stall_f_i = 1'b1;
    stall_d_i = 1'b0;
    flush_d_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    stall_f_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0; pc_src_e_i = 1'b0;
    pc_target_addr_e_i = '0;
    imem_req_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++; if (valid_d_o !== 1'b0) $display("FAIL reset_valid: got %b required 0", valid_d_o); else pass_cnt++;
    chk_cnt++; if (instr_d_o !== NOP) $display("FAIL reset_instr: got %h required %h", instr_d_o, NOP); else pass_cnt++;
    chk_cnt++; if (pc_d_o !== 32'd0) $display("FAIL reset_pc_d: got %h required 0", pc_d_o); else pass_cnt++;
    chk_cnt++; if (pc_plus_4_d_o !== 32'd0) $display("FAIL reset_pc4_d: got %h required 0", pc_plus_4_d_o); else pass_cnt++;
    chk_cnt++; if (pc_f_o !== RST_PC) $display("FAIL reset_pc_f: got %h required %h", pc_f_o, RST_PC); else pass_cnt++;
    chk_cnt++; if (imem_req_valid_o !== 1'b0) $display("FAIL reset_req_valid: got %b required 0", imem_req_valid_o); else pass_cnt++;
  endtask

  task automatic test_sequence();
    logic [31:0] a;
    bit ok;
    int unsigned c1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_hs(a, ok);
    chk_cnt++; if (!ok || a !== RST_PC) $display("FAIL seq_addr0: got %h ok=%b required %h", a, ok, RST_PC); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_cnt++;
    if (valid_d_o !== 1'b1 || pc_d_o !== RST_PC || pc_plus_4_d_o !== RST_PC + 32'd4 || instr_d_o !== mem_word(RST_PC))
      $display("FAIL seq_first_ifid: got v=%b pc=%h pc4=%h instr=%h required v=1 pc=%h", valid_d_o, pc_d_o, pc_plus_4_d_o, instr_d_o, RST_PC);
    else pass_cnt++;
    wait_hs(a, ok);
    c1 = cyc;
    chk_cnt++; if (!ok || a !== RST_PC + 32'd4) $display("FAIL seq_addr1: got %h ok=%b required %h", a, ok, RST_PC + 32'd4); else pass_cnt++;
    @(negedge clk);
    wait_hs(a, ok);
    chk_cnt++; if (!ok || a !== RST_PC + 32'd8) $display("FAIL seq_addr2: got %h ok=%b required %h", a, ok, RST_PC + 32'd8); else pass_cnt++;
    chk_cnt++; if (cyc - c1 !== 2) $display("FAIL seq_throughput: got %0d cycles between accepts required 2", cyc - c1); else pass_cnt++;
    drain();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL seq_drain: got %0d pending words required 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_stall_hold();
    logic [31:0] a, s_instr;
    logic s_valid;
    bit ok;
    stall_f_i = 1'b0;
    wait_hs(a, ok);
    chk_cnt++; if (!ok) $display("FAIL stall_accept: got no accept required one"); else pass_cnt++;
    @(negedge clk);
    stall_d_i = 1'b1;   // response arrives in this F_WAIT cycle
    #1;
    s_instr = instr_d_o;
    s_valid = valid_d_o;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk_cnt++;
      if (instr_d_o !== s_instr || valid_d_o !== s_valid)
        $display("FAIL stall_hold_%0d: got v=%b instr=%h required v=%b instr=%h", k, valid_d_o, instr_d_o, s_valid, s_instr);
      else pass_cnt++;
    end
    stall_d_i = 1'b0;
    stall_f_i = 1'b1;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (valid_d_o !== 1'b1 || pc_d_o !== a || instr_d_o !== mem_word(a))
      $display("FAIL stall_release: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h", valid_d_o, pc_d_o, instr_d_o, a, mem_word(a));
    else pass_cnt++;
    drain();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL stall_lost: got %0d pending words required 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_redirect_drop();
    logic [31:0] a;
    bit ok;
    stall_f_i = 1'b0;
    rsp_lat   = 2;
    wait_hs(a, ok);
    @(negedge clk);
    pc_src_e_i = 1'b1;
    pc_target_addr_e_i = 32'h0000_0200;
    @(negedge clk);
    pc_src_e_i = 1'b0;
    rsp_lat    = 1;
    #1;
    chk_cnt++;
    if (valid_d_o !== 1'b0 || pc_f_o !== 32'h200 || imem_req_valid_o !== 1'b0)
      $display("FAIL drop_wait: got v=%b pc_f=%h req=%b required v=0 pc_f=200 req=0", valid_d_o, pc_f_o, imem_req_valid_o);
    else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h200 || valid_d_o !== 1'b0)
      $display("FAIL drop_next_req: got req=%b addr=%h v=%b required req=1 addr=200 v=0", imem_req_valid_o, imem_addr_o, valid_d_o);
    else pass_cnt++;
    wait_hs(a, ok);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_cnt++;
    if (valid_d_o !== 1'b1 || pc_d_o !== 32'h200)
      $display("FAIL drop_target_load: got v=%b pc_d=%h required v=1 pc_d=200", valid_d_o, pc_d_o);
    else pass_cnt++;
    drain();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL drop_drain: got %0d pending words required 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_redirect_rsp_stall();
    logic [31:0] a;
    bit ok;
    stall_f_i = 1'b0;
    wait_hs(a, ok);
    @(negedge clk);
    stall_d_i  = 1'b1;
    pc_src_e_i = 1'b1;
    pc_target_addr_e_i = 32'h0000_0300;
    @(negedge clk);
    stall_d_i  = 1'b0;
    pc_src_e_i = 1'b0;
    #1;
    chk_cnt++;
    if (valid_d_o !== 1'b0 || instr_d_o !== NOP || imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h300)
      $display("FAIL redir_rsp: got v=%b instr=%h req=%b addr=%h required v=0 instr=%h req=1 addr=300", valid_d_o, instr_d_o, imem_req_valid_o, imem_addr_o, NOP);
    else pass_cnt++;
    wait_hs(a, ok);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_cnt++;
    if (valid_d_o !== 1'b1 || pc_d_o !== 32'h300 || instr_d_o !== mem_word(32'h300))
      $display("FAIL redir_rsp_load: got v=%b pc_d=%h instr=%h required v=1 pc_d=300", valid_d_o, pc_d_o, instr_d_o);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_ready_low();
    logic [4:0]  pat;
    logic [31:0] a0;
    int n_acc;
    pat = 5'b11010;
    @(negedge clk);
    imem_req_ready_i = 1'b0;
    #1;
    a0 = pc_f_o;
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      stall_f_i = pat[k];
      #1;
      chk_cnt++;
      if (imem_req_valid_o !== !pat[k] || imem_addr_o !== a0)
        $display("FAIL ready_low_%0d: got req=%b addr=%h required req=%b addr=%h", k, imem_req_valid_o, imem_addr_o, !pat[k], a0);
      else pass_cnt++;
      if (imem_req_valid_o && imem_req_ready_i) n_acc++;
      @(negedge clk);
    end
    imem_req_ready_i = 1'b1;
    stall_f_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (imem_req_valid_o && imem_req_ready_i) n_acc++;
      @(negedge clk);
    end
    chk_cnt++; if (n_acc !== 1) $display("FAIL ready_accepts: got %0d required 1", n_acc); else pass_cnt++;
    drain();
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    bit ok;
    @(negedge clk);
    pc_src_e_i = 1'b1;
    pc_target_addr_e_i = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_src_e_i = 1'b0;
    stall_f_i  = 1'b0;
    wait_hs(a, ok);
    chk_cnt++; if (a !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h required fffffffc", a); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_cnt++;
    if (pc_d_o !== 32'hFFFF_FFFC || pc_plus_4_d_o !== 32'd0 || pc_f_o !== 32'd0)
      $display("FAIL wrap_pc4: got pc_d=%h pc4=%h pc_f=%h required fffffffc 0 0", pc_d_o, pc_plus_4_d_o, pc_f_o);
    else pass_cnt++;
    wait_hs(a, ok);
    chk_cnt++; if (a !== 32'd0) $display("FAIL wrap_next: got %h required 0", a); else pass_cnt++;
    drain();
  endtask

  task automatic test_flush();
    logic [31:0] a;
    bit ok;
    stall_f_i = 1'b0;
    wait_hs(a, ok);
    @(negedge clk);
    stall_f_i = 1'b1;
    @(negedge clk);
    stall_d_i = 1'b1;
    #1;
    chk_cnt++; if (valid_d_o !== 1'b1 || pc_d_o !== a) $display("FAIL flush_pre: got v=%b pc=%h required v=1 pc=%h", valid_d_o, pc_d_o, a); else pass_cnt++;
    @(negedge clk);
    flush_d_i = 1'b1;
    @(negedge clk);
    flush_d_i = 1'b0;
    #1;
    chk_cnt++;
    if (valid_d_o !== 1'b0 || instr_d_o !== NOP)
      $display("FAIL flush_over_stall: got v=%b instr=%h required v=0 instr=%h", valid_d_o, instr_d_o, NOP);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    bit ok;
    stall_f_i = 1'b0;
    rsp_lat   = 3;
    wait_hs(a, ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (imem_req_valid_o !== 1'b0 || pc_f_o !== RST_PC || valid_d_o !== 1'b0)
      $display("FAIL rstmid_in_reset: got req=%b pc_f=%h v=%b required req=0 pc_f=%h v=0", imem_req_valid_o, pc_f_o, valid_d_o, RST_PC);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    stall_f_i = 1'b1;
    @(negedge clk);   // stale response arrives in this cycle
    #1;
    chk_cnt++; if (valid_d_o !== 1'b0) $display("FAIL rstmid_pre_rsp: got v=%b required 0", valid_d_o); else pass_cnt++;
    @(negedge clk);
    stall_f_i = 1'b0;
    rsp_lat   = 1;
    #1;
    chk_cnt++;
    if (valid_d_o !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_addr_o !== RST_PC)
      $display("FAIL rstmid_restart: got v=%b req=%b addr=%h required v=0 req=1 addr=%h", valid_d_o, imem_req_valid_o, imem_addr_o, RST_PC);
    else pass_cnt++;
    wait_hs(a, ok);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_cnt++;
    if (valid_d_o !== 1'b1 || pc_d_o !== RST_PC || instr_d_o !== mem_word(RST_PC))
      $display("FAIL rstmid_first_load: got v=%b pc=%h instr=%h required v=1 pc=%h", valid_d_o, pc_d_o, instr_d_o, RST_PC);
    else pass_cnt++;
    drain();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL rstmid_drain: got %0d pending words required 0", exp_q.size()); else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_sequence();
    test_stall_hold();
    test_redirect_drop();
    test_redirect_rsp_stall();
    test_ready_low();
    test_wrap();
    test_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
